cpu_datapath: RTL

- 16-bit accumulator datapath driven cycle-by-cycle by the CPU control FSM's load/inc/select strobes.
- Holds PC, AR, IR, DR, AC, FLAGS and a 16-entry general register file, plus the ALU.
- Drives the external synchronous instruction/data RAM, and returns IR_Value and FLAGS_Value to the control unit.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/cpu_alu.sv | 63 ++++++
 rtl/cpu_datapath.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU: ALU and bus codes, flag bit
// positions, default widths and the opcode map used by the control unit.
package cpu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_NREGS  = 16;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOT  = 4'h5,
    ALU_SHL  = 4'h6,
    ALU_SHR  = 4'h7,
    ALU_PASS = 4'h8
  } alu_op_e;

  typedef enum logic [2:0] {
    BUS_IR_ADDR = 3'd0,
    BUS_DR      = 3'd1,
    BUS_AC      = 3'd2,
    BUS_PC      = 3'd3,
    BUS_REG     = 3'd4,
    BUS_MEM     = 3'd5,
    BUS_ZERO    = 3'd6
  } bus_sel_e;

  // Bit positions inside FLAGS = {Z,N,C,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Opcode field IR[15:12] as decoded by the control unit
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDA   = 4'h1;
  localparam logic [3:0] OP_STA   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_JZ    = 4'h6;
  localparam logic [3:0] OP_MOVR  = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
    return ir[15:12];
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: y = f(a, b) selected by alu_sel, plus {Z,N,C,V}.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] y,
  output logic [3:0]        flags
);

  logic [DATA_W:0] sum;
  logic            c;
  logic            v;

  // Operation select; SUB uses a + ~b + 1 so the carry-out is the no-borrow flag
  always_comb begin
    sum = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        y   = sum[DATA_W-1:0];
        c   = sum[DATA_W];
        v   = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOT:  y = ~a;
      ALU_SHL: begin
        y = {a[DATA_W-2:0], 1'b0};
        c = a[DATA_W-1];
      end
      ALU_SHR: begin
        y = {1'b0, a[DATA_W-1:1]};
        c = a[0];
      end
      ALU_PASS: y = b;
      default:  y = '0;
    endcase
  end

  // Flag vector packing
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (y == '0);
    flags[FLAG_N] = y[DATA_W-1];
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC/AR/IR/DR/AC/FLAGS, 16-entry register file,
// internal bus and ALU, all stepped by strobes from the control FSM.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = DEF_NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IR_Load,
  input  logic              DR_Load,
  input  logic              PC_Load,
  input  logic              AR_Load,
  input  logic              AC_Load,
  input  logic              FLAGS_Load,
  input  logic              AC_Inc,
  input  logic              PC_Inc,
  input  logic              DR_Inc,
  input  logic              write_en,
  input  logic [3:0]        alu_sel,
  input  logic [2:0]        bus_sel,
  input  logic [3:0]        reg_sel,
  input  logic [3:0]        reg_write_sel,
  input  logic              reg_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [15:0]       IR_Value,
  output logic [3:0]        FLAGS_Value,
  output logic [DATA_W-1:0] AC_Value,
  output logic [ADDR_W-1:0] PC_Value
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ar;
  logic [15:0]       ir;
  logic [DATA_W-1:0] dr;
  logic [DATA_W-1:0] ac;
  logic [3:0]        flags;
  logic [DATA_W-1:0] regs [NREGS];

  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_y;
  logic [3:0]        alu_flags;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a       (ac),
    .b       (dr),
    .alu_sel (alu_sel),
    .y       (alu_y),
    .flags   (alu_flags)
  );

  // Internal bus source mux; narrow sources are zero-extended
  always_comb begin
    bus = '0;
    case (bus_sel)
      BUS_IR_ADDR: bus[ADDR_W-1:0] = ir[ADDR_W-1:0];
      BUS_DR:      bus = dr;
      BUS_AC:      bus = ac;
      BUS_PC:      bus[ADDR_W-1:0] = pc;
      BUS_REG:     bus = regs[reg_sel];
      BUS_MEM:     bus = mem_rdata;
      default:     bus = '0;
    endcase
  end

  // Architectural registers; Load takes priority over Inc
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= '0;
      ar    <= '0;
      ir    <= '0;
      dr    <= '0;
      ac    <= '0;
      flags <= '0;
    end else begin
      if (AR_Load) ar <= bus[ADDR_W-1:0];

      if (PC_Load)     pc <= bus[ADDR_W-1:0];
      else if (PC_Inc) pc <= pc + ADDR_W'(1);

      if (IR_Load) ir <= mem_rdata[15:0];

      // With the register source selected the bus carries R[reg_sel]
      if (DR_Load)     dr <= (bus_sel == BUS_REG) ? bus : mem_rdata;
      else if (DR_Inc) dr <= dr + DATA_W'(1);

      if (AC_Load)     ac <= alu_y;
      else if (AC_Inc) ac <= ac + DATA_W'(1);

      if (FLAGS_Load) flags <= alu_flags;
    end
  end

  // Register file write port; stores the pre-edge accumulator
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[reg_write_sel] <= ac;
    end
  end

  assign mem_addr    = ar;
  assign mem_wdata   = ac;
  assign mem_we      = write_en;
  assign IR_Value    = ir;
  assign FLAGS_Value = flags;
  assign AC_Value    = ac;
  assign PC_Value    = pc;

endmodule
